pstprc_iq_uploader: RTL and testbench

Reader side of the post-processing result FIFO. After each demodulation pass (`Dmod_Seg` pulses `Pstprc_finish` and has pushed `Pstprc_num` 64-bit IQ words via `pstprc_fifo_wren`), this block:
- pops those words from the FIFO;
- frames them;
- streams them byte-wise to the Ethernet TX MAC under a valid/ready handshake.

It sits between the post-process FIFO read port and the upload MAC.

---
 rtl/pstprc_iq_uploader_pkg.sv | 26 ++
 rtl/pstprc_iq_uploader_if.sv | 24 ++
 rtl/pstprc_iq_uploader_shifter.sv | 43 ++++
 rtl/pstprc_iq_uploader.sv | 165 ++++++++++++++++
 tb/tb_pstprc_iq_uploader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pstprc_iq_uploader_pkg.sv
// Shared types and constants for the post-process IQ uploader.
// Frame: HDR0 HDR1 CNT {IQ bytes} CKSUM, checksum over CNT and IQ bytes only.
package pstprc_pkg;

  localparam int IQ_W  = 64;
  localparam int CNT_W = 4;

  localparam logic [7:0] HDR0_DEF = 8'hEB;
  localparam logic [7:0] HDR1_DEF = 8'h90;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H0,
    ST_H1,
    ST_CNT,
    ST_FETCH,
    ST_WAIT,
    ST_DATA,
    ST_CKS
  } state_e;

  function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/pstprc_iq_uploader_if.sv
// FIFO read port and byte-wide MAC TX handshake seen by the uploader.
interface pstprc_iq_uploader_if;
  import pstprc_pkg::*;

  logic            fifo_empty;
  logic            fifo_rden;
  logic [IQ_W-1:0] fifo_dout;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            tx_sof;
  logic            tx_eof;

  modport master (
    input  fifo_empty, fifo_dout, tx_ready,
    output fifo_rden, tx_data, tx_valid, tx_sof, tx_eof
  );

  modport slave (
    output fifo_empty, fifo_dout, tx_ready,
    input  fifo_rden, tx_data, tx_valid, tx_sof, tx_eof
  );

endinterface

// File: rtl/pstprc_iq_uploader_shifter.sv
// 64-bit load / shift-by-8 register presenting one IQ word MSB byte first.
// byte_nxt_o is the top byte after this cycle's update so it can feed a registered output.
module iq_byte_shifter
  import pstprc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic [IQ_W-1:0] data_i,
  output logic [7:0]      byte_nxt_o,
  output logic            last_byte_o
);

  logic [IQ_W-1:0] shreg_q, shreg_d;
  logic [2:0]      idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load_i) begin
      shreg_d = data_i;
      idx_d   = 3'd0;
    end else if (shift_i) begin
      shreg_d = {shreg_q[IQ_W-9:0], 8'h00};
      idx_d   = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_nxt_o  = shreg_d[IQ_W-1 -: 8];
  assign last_byte_o = (idx_q == 3'd7);

endmodule

// File: rtl/pstprc_iq_uploader.sv
// Pops N IQ words from the post-process FIFO after each demod pass and streams
// them as a framed byte stream to the TX MAC. All outputs are registered.
module pstprc_iq_uploader
  import pstprc_pkg::*;
#(
  parameter logic [7:0] HDR0 = HDR0_DEF,
  parameter logic [7:0] HDR1 = HDR1_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Pstprc_finish,
  input  logic [CNT_W-1:0] Pstprc_num,
  output logic             busy,
  output logic             drop_pulse,
  pstprc_iq_uploader_if.master up_if
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       cksum_q, cksum_d;

  logic       rden_q, rden_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       tx_sof_q, tx_sof_d;
  logic       tx_eof_q, tx_eof_d;
  logic       busy_q, busy_d;
  logic       drop_q, drop_d;

  logic       hs;
  logic       sh_load;
  logic       sh_shift;
  logic [7:0] sh_byte_nxt;
  logic       sh_last;

  assign hs       = tx_valid_q && up_if.tx_ready;
  assign sh_load  = (state_q == ST_WAIT);
  assign sh_shift = (state_q == ST_DATA) && hs;

  iq_byte_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (sh_load),
    .shift_i    (sh_shift),
    .data_i     (up_if.fifo_dout),
    .byte_nxt_o (sh_byte_nxt),
    .last_byte_o(sh_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cksum_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cksum_q <= cksum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cksum_d = cksum_q;
    case (state_q)
      ST_IDLE: begin
        if (Pstprc_finish) begin
          rem_d   = Pstprc_num;
          cksum_d = '0;
          state_d = ST_H0;
        end
      end
      ST_H0: if (hs) state_d = ST_H1;
      ST_H1: if (hs) state_d = ST_CNT;
      ST_CNT: begin
        if (hs) begin
          cksum_d = cksum_add(cksum_q, tx_data_q);
          state_d = (rem_q != '0) ? ST_FETCH : ST_CKS;
        end
      end
      // The read pulse is already on the bus while in FETCH, so leave once it is seen.
      ST_FETCH: if (rden_q) state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_DATA;
      ST_DATA: begin
        if (hs) begin
          cksum_d = cksum_add(cksum_q, tx_data_q);
          if (sh_last) begin
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q != CNT_W'(1)) ? ST_FETCH : ST_CKS;
          end
        end
      end
      ST_CKS:  if (hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs describe the state being entered, so they are valid the cycle it is occupied.
  // We are the only reader, so a non-empty flag seen now still holds when the pop lands.
  always_comb begin
    rden_d     = (state_d == ST_FETCH) && !up_if.fifo_empty;
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    tx_sof_d   = (state_d == ST_H0);
    tx_eof_d   = (state_d == ST_CKS);
    busy_d     = (state_d != ST_IDLE);
    drop_d     = Pstprc_finish && (state_q != ST_IDLE);
    case (state_d)
      ST_H0: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HDR0;
      end
      ST_H1: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HDR1;
      end
      ST_CNT: begin
        tx_valid_d = 1'b1;
        tx_data_d  = {{(8-CNT_W){1'b0}}, rem_d};
      end
      ST_DATA: begin
        tx_valid_d = 1'b1;
        tx_data_d  = sh_byte_nxt;
      end
      ST_CKS: begin
        tx_valid_d = 1'b1;
        tx_data_d  = cksum_d;
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rden_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_sof_q   <= 1'b0;
      tx_eof_q   <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      rden_q     <= rden_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_sof_q   <= tx_sof_d;
      tx_eof_q   <= tx_eof_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign up_if.fifo_rden = rden_q;
  assign up_if.tx_data   = tx_data_q;
  assign up_if.tx_valid  = tx_valid_q;
  assign up_if.tx_sof    = tx_sof_q;
  assign up_if.tx_eof    = tx_eof_q;
  assign busy            = busy_q;
  assign drop_pulse      = drop_q;

endmodule

// File: tb/tb_pstprc_iq_uploader.sv
// Directed-plus-random bench: a queue FIFO model feeds the uploader, a monitor
// collects accepted bytes, and each frame is compared with one built from the frame rules.
module tb_pstprc_iq_uploader;
  import pstprc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Pstprc_finish;
  logic [3:0] Pstprc_num;
  logic       busy;
  logic       drop_pulse;

  always #5 clk = ~clk;

  pstprc_iq_uploader_if up_if ();

  pstprc_iq_uploader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Pstprc_finish(Pstprc_finish),
    .Pstprc_num   (Pstprc_num),
    .busy         (busy),
    .drop_pulse   (drop_pulse),
    .up_if        (up_if)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // FIFO model
  logic [63:0] fq[$];
  logic        push_req  = 1'b0;
  logic        flush_req = 1'b0;
  logic [63:0] push_word = '0;
  int          underflow = 0;

  always @(posedge clk) begin
    if (flush_req) fq.delete();
    if (push_req) fq.push_back(push_word);
    if (up_if.fifo_rden === 1'b1) begin
      if (fq.size() > 0) up_if.fifo_dout <= fq.pop_front();
      else underflow <= underflow + 1;
    end
    up_if.fifo_empty <= (fq.size() == 0);
  end

  // Monitor
  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    int         cyc;
  } rx_t;

  rx_t        rx_q[$];
  int         cyc      = 0;
  int         rden_cnt = 0;
  int         drop_cnt = 0;
  int         gap_cnt  = 0;
  int         stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_out   = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n !== 1'b1) begin
      prev_stall <= 1'b0;
    end else begin
      if (up_if.fifo_rden === 1'b1) rden_cnt <= rden_cnt + 1;
      if (drop_pulse === 1'b1) drop_cnt <= drop_cnt + 1;
      if (busy === 1'b1 && up_if.tx_valid !== 1'b1) gap_cnt <= gap_cnt + 1;
      if (prev_stall && !(up_if.tx_valid === 1'b1 &&
          {up_if.tx_sof, up_if.tx_eof, up_if.tx_data} === prev_out))
        stab_err <= stab_err + 1;
      if (up_if.tx_valid === 1'b1 && up_if.tx_ready === 1'b1)
        rx_q.push_back('{d: up_if.tx_data, sof: up_if.tx_sof, eof: up_if.tx_eof, cyc: cyc});
      prev_stall <= (up_if.tx_valid === 1'b1) && (up_if.tx_ready !== 1'b1);
      prev_out   <= {up_if.tx_sof, up_if.tx_eof, up_if.tx_data};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rden"},  64'(up_if.fifo_rden), 64'd0);
    check({tag, ".data"},  64'(up_if.tx_data),   64'd0);
    check({tag, ".valid"}, 64'(up_if.tx_valid),  64'd0);
    check({tag, ".sof"},   64'(up_if.tx_sof),    64'd0);
    check({tag, ".eof"},   64'(up_if.tx_eof),    64'd0);
    check({tag, ".busy"},  64'(busy),            64'd0);
    check({tag, ".drop"},  64'(drop_pulse),      64'd0);
  endtask

  task automatic push(input logic [63:0] w);
    @(negedge clk);
    push_req  = 1'b1;
    push_word = w;
    @(negedge clk);
    push_req  = 1'b0;
  endtask

  task automatic flush();
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
  endtask

  task automatic pulse_finish(input int n);
    @(negedge clk);
    Pstprc_finish = 1'b1;
    Pstprc_num    = 4'(n);
    @(negedge clk);
    Pstprc_finish = 1'b0;
  endtask

  // Waits for busy to fall; optionally randomises tx_ready and pushes a word at step push_at.
  task automatic wait_frame(input string tag, input int limit, input bit rand_rdy,
                            input int push_at, input logic [63:0] pw);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      push_req  = (i == push_at);
      push_word = pw;
      if (rand_rdy) up_if.tx_ready = 1'($urandom_range(0, 1));
      if (busy === 1'b0 && i > push_at) done = 1'b1;
    end
    push_req       = 1'b0;
    up_if.tx_ready = 1'b1;
    check({tag, ".done"}, 64'(done), 64'd1);
  endtask

  // Reference frame: headers, count, N words big-endian, 8-bit sum of count and IQ bytes.
  task automatic check_frame(input string tag, input int base, input int n, input logic [63:0] w[$]);
    logic [7:0] e[$];
    logic [7:0] sum;
    int         got;
    e.push_back(HDR0_DEF);
    e.push_back(HDR1_DEF);
    e.push_back(8'(n));
    sum = 8'(n);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        logic [7:0] by;
        by  = w[i][63-8*b -: 8];
        sum = sum + by;
        e.push_back(by);
      end
    end
    e.push_back(sum);
    got = rx_q.size() - base;
    check($sformatf("%s.len", tag), 64'(got), 64'(e.size()));
    for (int k = 0; k < e.size() && k < got; k++) begin
      check($sformatf("%s.b%0d", tag, k),   64'(rx_q[base+k].d),   64'(e[k]));
      check($sformatf("%s.sof%0d", tag, k), 64'(rx_q[base+k].sof), 64'(k == 0));
      check($sformatf("%s.eof%0d", tag, k), 64'(rx_q[base+k].eof), 64'(k == e.size() - 1));
    end
  endtask

  initial begin
    logic [63:0] w[$];
    int base, r0, d0, g0, eofs;
    bit  got6;

    rst_n          = 1'b0;
    Pstprc_finish  = 1'b0;
    Pstprc_num     = 4'd0;
    up_if.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // N=1 known word, latency and frame length
    w = {};
    w.push_back(64'h0102030405060708);
    push(w[0]);
    base = rx_q.size();
    r0   = rden_cnt;
    pulse_finish(1);
    check("n1.first_valid", 64'(up_if.tx_valid), 64'd1);
    check("n1.first_data",  64'(up_if.tx_data),  64'hEB);
    check("n1.first_sof",   64'(up_if.tx_sof),   64'd1);
    check("n1.busy",        64'(busy),           64'd1);
    wait_frame("n1", 200, 1'b0, -1, '0);
    check_frame("n1", base, 1, w);
    if (rx_q.size() == base + 12) begin
      check("n1.cksum", 64'(rx_q[base+11].d), 64'h25);
      check("n1.cycles", 64'(rx_q[base+11].cyc - rx_q[base].cyc + 1), 64'd14);
    end
    check("n1.rden", 64'(rden_cnt - r0), 64'd1);

    // N=0
    base = rx_q.size();
    r0   = rden_cnt;
    pulse_finish(0);
    wait_frame("n0", 100, 1'b0, -1, '0);
    w = {};
    check_frame("n0", base, 0, w);
    check("n0.rden", 64'(rden_cnt - r0), 64'd0);
    check("n0.busy", 64'(busy), 64'd0);

    // N=3 random words, random backpressure
    w = {};
    for (int i = 0; i < 3; i++) begin
      w.push_back({$urandom, $urandom});
      push(w[i]);
    end
    base = rx_q.size();
    pulse_finish(3);
    wait_frame("n3", 600, 1'b1, -1, '0);
    check_frame("n3", base, 3, w);
    check("n3.stable", 64'(stab_err), 64'd0);

    // N=2, second word arrives late
    w = {};
    w.push_back({$urandom, $urandom});
    w.push_back({$urandom, $urandom});
    push(w[0]);
    base = rx_q.size();
    g0   = gap_cnt;
    pulse_finish(2);
    wait_frame("late", 300, 1'b0, 25, w[1]);
    check_frame("late", base, 2, w);
    check("late.gap", 64'((gap_cnt - g0) >= 12), 64'd1);

    // Finish during a frame is dropped
    w = {};
    w.push_back({$urandom, $urandom});
    w.push_back({$urandom, $urandom});
    push(w[0]);
    push(w[1]);
    base = rx_q.size();
    r0   = rden_cnt;
    d0   = drop_cnt;
    pulse_finish(2);
    repeat (4) @(negedge clk);
    pulse_finish(7);
    wait_frame("drop", 300, 1'b0, -1, '0);
    check_frame("drop", base, 2, w);
    check("drop.pulses", 64'(drop_cnt - d0), 64'd1);
    check("drop.rden",   64'(rden_cnt - r0), 64'd2);
    repeat (30) @(negedge clk);
    check("drop.no_second", 64'(rx_q.size() - base), 64'd20);
    check("drop.idle_busy", 64'(busy), 64'd0);

    // Reset in DATA of an N=4 frame, then a clean N=1 frame
    for (int i = 0; i < 4; i++) push({$urandom, $urandom});
    base = rx_q.size();
    pulse_finish(4);
    got6 = 1'b0;
    for (int i = 0; i < 100 && !got6; i++) begin
      @(negedge clk);
      if (rx_q.size() >= base + 6) got6 = 1'b1;
    end
    check("rst.reached_data", 64'(got6), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero("rst.mid");
    eofs = 0;
    for (int k = base; k < rx_q.size(); k++) if (rx_q[k].eof === 1'b1) eofs++;
    check("rst.no_eof", 64'(eofs), 64'd0);
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = {};
    w.push_back({$urandom, $urandom});
    push(w[0]);
    base = rx_q.size();
    pulse_finish(1);
    wait_frame("post_rst", 200, 1'b0, -1, '0);
    check_frame("post_rst", base, 1, w);

    check("underflow", 64'(underflow), 64'd0);
    check("stable_all", 64'(stab_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
